// File: rtl/pulse_wave.sv
// rtl/pulse_wave.sv - bipolar pulse-wave tone source with glitch-free period/duty/amplitude updates
// Define PULSE_WAVE_DUTY_EN to enable the programmable duty cycle; otherwise a pure square wave.
module pulse_wave #(
  parameter int PERIOD_W = 19,
  parameter int DUTY_W   = 8,
  parameter int OUT_W    = 16
) (
  input  logic                clk48m,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DUTY_W-1:0]   duty,
  input  logic [OUT_W-2:0]    amplitude,
  input  logic                sync,
  output logic [OUT_W-1:0]    value,
  output logic                wrap
);

  logic [PERIOD_W-1:0] per_q;
  logic [PERIOD_W-1:0] thr_q;
  logic [PERIOD_W-1:0] c;
  logic [PERIOD_W-1:0] c_next;
  logic [PERIOD_W-1:0] thr_raw;
  logic [PERIOD_W-1:0] thr_new;
  logic [OUT_W-2:0]    amp_q;
  logic [OUT_W-1:0]    amp_pos;
  logic                commit;

  assign c_next  = c + PERIOD_W'(1);
  assign amp_pos = {1'b0, amp_q};
  // per_q==0 (mute) commits every cycle, so the c==per_q-1 underflow never matters.
  assign commit  = (per_q == '0) || (c == per_q - PERIOD_W'(1)) || sync;

`ifdef PULSE_WAVE_DUTY_EN
  logic [PERIOD_W+DUTY_W-1:0] prod;

  assign prod    = {{DUTY_W{1'b0}}, period} * {{PERIOD_W{1'b0}}, duty};
  assign thr_raw = (duty != '0) ? prod[PERIOD_W+DUTY_W-1:DUTY_W] : (period >> 1);
`else
  logic unused_duty;

  assign unused_duty = ^duty;
  assign thr_raw     = period >> 1;
`endif

  // Phase 0 is always high, so a nonzero period needs at least one high cycle.
  assign thr_new = ((period != '0) && (thr_raw == '0)) ? PERIOD_W'(1) : thr_raw;

  always_ff @(posedge clk48m or posedge rst) begin
    if (rst) begin
      per_q <= '0;
      thr_q <= '0;
      amp_q <= '0;
      c     <= '0;
      value <= '0;
      wrap  <= 1'b0;
    end else if (commit) begin
      per_q <= period;
      amp_q <= amplitude;
      thr_q <= thr_new;
      c     <= '0;
      if (period == '0) begin
        value <= '0;
        wrap  <= 1'b0;
      end else begin
        value <= {1'b0, amplitude};
        wrap  <= 1'b1;
      end
    end else begin
      c     <= c_next;
      wrap  <= 1'b0;
      value <= (c_next < thr_q) ? amp_pos : -amp_pos;
    end
  end

endmodule

// File: tb/tb_pulse_wave.sv
// tb/tb_pulse_wave.sv - self-checking bench for pulse_wave: vector table, directed corners, random vs model
// Honours PULSE_WAVE_DUTY_EN the same way as the design.
module tb_pulse_wave;
  localparam int PW = 19;
  localparam int DW = 8;
  localparam int OW = 16;
`ifdef PULSE_WAVE_DUTY_EN
  localparam bit DUTY_EN = 1'b1;
`else
  localparam bit DUTY_EN = 1'b0;
`endif

  logic          clk48m = 1'b0;
  logic          rst;
  logic [PW-1:0] period;
  logic [DW-1:0] duty;
  logic [OW-2:0] amplitude;
  logic          sync;
  logic [OW-1:0] value;
  logic          wrap;

  int checks = 0;
  int errors = 0;

  pulse_wave #(.PERIOD_W(PW), .DUTY_W(DW), .OUT_W(OW)) dut (
    .clk48m(clk48m), .rst(rst), .period(period), .duty(duty),
    .amplitude(amplitude), .sync(sync), .value(value), .wrap(wrap)
  );

  always #5 clk48m = ~clk48m;

  // Reference model: each commit lays out the whole period as a list of samples.
  typedef struct {logic [OW-1:0] v; logic w;} samp_t;
  samp_t         mq[$];
  logic [OW-1:0] mv;
  logic          mw;

  typedef struct {int per; int dty; int amp; int hi;} vec_t;
  vec_t tbl[9];

  function automatic int ref_thr(int p, int d);
    int t = p / 2;
    if (DUTY_EN && d != 0) t = (p * d) / (1 << DW);
    if (p != 0 && t < 1) t = 1;
    return t;
  endfunction

  task automatic model_step();
    samp_t s;
    if (sync || mq.size() == 0) begin
      int p = int'(period);
      int t = ref_thr(p, int'(duty));
      int a = int'(amplitude);
      mq.delete();
      if (p == 0) begin
        s.v = '0; s.w = 1'b0; mq.push_back(s);
      end else begin
        for (int i = 0; i < p; i++) begin
          s.v = (i < t) ? OW'(a) : OW'(-a);
          s.w = (i == 0);
          mq.push_back(s);
        end
      end
    end
    s  = mq.pop_front();
    mv = s.v;
    mw = s.w;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk48m);
    @(negedge clk48m);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [OW-1:0] ev, input logic ew);
    chk({name, " value"}, 32'(value), 32'(ev));
    chk({name, " wrap"}, 32'(wrap), 32'(ew));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mq.delete();
    mv = '0;
    mw = 1'b0;
    #2;
    check_out("reset", 16'h0000, 1'b0);
    @(posedge clk48m);
    @(negedge clk48m);
    rst = 1'b0;
  endtask

  initial begin
    int ph;
    int r;
    logic [OW-1:0] pos;
    logic [OW-1:0] neg;

    tbl[0] = '{8,  0,   'h7FFF, 4};
    tbl[1] = '{4,  0,   'h0100, 2};
    tbl[2] = '{10, 64,  'h1000, DUTY_EN ? 2 : 5};
    tbl[3] = '{10, 1,   'h1000, DUTY_EN ? 1 : 5};
    tbl[4] = '{7,  0,   'h0AAA, 3};
    tbl[5] = '{1,  0,   'h1234, 1};
    tbl[6] = '{2,  0,   'h0005, 1};
    tbl[7] = '{3,  255, 'h0040, DUTY_EN ? 2 : 1};
    tbl[8] = '{6,  0,   'h0000, 3};

    period = '0; duty = '0; amplitude = 15'h7FFF; sync = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle();
      check_out($sformatf("mute%0d", i), 16'h0000, 1'b0);
    end

    for (int i = 0; i < 9; i++) begin
      period = PW'(tbl[i].per); duty = DW'(tbl[i].dty); amplitude = (OW-1)'(tbl[i].amp);
      pos = OW'(tbl[i].amp);
      neg = OW'(-tbl[i].amp);
      sync = 1'b1;
      cycle();
      sync = 1'b0;
      for (int k = 0; k < 2 * tbl[i].per; k++) begin
        if (k > 0) cycle();
        ph = k % tbl[i].per;
        check_out($sformatf("row%0d k%0d", i, k), (ph < tbl[i].hi) ? pos : neg, ph == 0);
      end
    end

    // Period change at phase 2 must wait for the current 8-cycle period to end.
    period = 8; duty = '0; amplitude = 15'h7FFF; sync = 1'b1;
    cycle();
    sync = 1'b0;
    cycle();
    cycle();
    period = 4;
    for (int p = 3; p < 8; p++) begin
      cycle();
      check_out($sformatf("defer p%0d", p), (p < 4) ? 16'h7FFF : 16'h8001, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      cycle();
      check_out($sformatf("short k%0d", k), (k % 4 < 2) ? 16'h7FFF : 16'h8001, (k % 4) == 0);
    end

    // Sync at phase 5 restarts a full period.
    period = 8; amplitude = 15'h0300; sync = 1'b1;
    cycle();
    sync = 1'b0;
    repeat (5) cycle();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    check_out("sync restart", 16'h0300, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      ph = k % 8;
      check_out($sformatf("sync k%0d", k), (ph < 4) ? 16'h0300 : 16'hFD00, ph == 0);
    end

    // period 1 holds high with wrap every cycle, then mute, then restart from mute.
    period = 1; amplitude = 15'h1234; sync = 1'b1;
    cycle();
    sync = 1'b0;
    check_out("p1 first", 16'h1234, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_out($sformatf("p1 k%0d", k), 16'h1234, 1'b1);
    end
    period = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_out($sformatf("p0 k%0d", k), 16'h0000, 1'b0);
    end
    period = 5;
    cycle();
    check_out("unmute", 16'h1234, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        do_reset();
      end else begin
        if (r < 16) period = ($urandom_range(0, 3) == 0) ? PW'(0) : PW'($urandom_range(1, 24));
        if (r < 24) amplitude = (OW-1)'($urandom);
        if (r < 32) duty = DW'($urandom_range(0, 255));
        sync = ($urandom_range(0, 29) == 0);
        cycle();
        sync = 1'b0;
        check_out($sformatf("rand%0d", i), mv, mw);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
